camera_capture: RTL and testbench
=================================

# camera_capture

Parametrised camera pixel-capture front end, the successor to the fixed RGB565 two-byte capture block. It samples the sensor's byte-serial DVP bus (`vsync`, `href`, `p_data`) in the pixel-clock domain and assembles 1–4 bytes into one pixel, with configurable byte order. It also supplies X/Y coordinates, line and frame strobes, frame arming, and frame-geometry error checking. It sits between the OV7670 sensor pins and the frame-buffer write port.

## Interface
- `BYTES_PER_PIXEL`, default 2: bytes per pixel, legal 1–4.
- `H_ACTIVE`, default 640: expected pixels per line.
- `V_ACTIVE`, default 480: expected lines per frame.
- `SWAP_BYTES`, default 0: 0 = first byte lands in the MSBs; 1 = first byte lands in the LSBs.
- `X_W`, default `$clog2(H_ACTIVE)`: X coordinate width.
- `Y_W`, default `$clog2(V_ACTIVE)`: Y coordinate width.

Ports (single clock; reset is synchronous and active-high):
- `p_clock` input 1: sensor pixel clock, the only clock.
- `reset` input 1: synchronous, active-high.
- `vsync` input 1: high = vertical blanking.
- `href` input 1: high = active line bytes.
- `p_data` input 8: sensor byte.
- `capture_en` input 1: arms capture; sampled only at frame start.
- `pixel_data` output 8*BYTES_PER_PIXEL: assembled pixel; holds its value between valids.
- `pixel_valid` output 1: one-cycle strobe.
- `pixel_x` output X_W: column of the current `pixel_data`.
- `pixel_y` output Y_W: row of the current `pixel_data`.
- `line_done` output 1: one-cycle strobe at the end of each captured line.
- `frame_done` output 1: one-cycle strobe at the end of a captured frame.
- `frame_error` output 1: geometry error flag; meaningful only while `frame_done` = 1.
- `frame_count` output 16: count of completed captured frames; wraps.

## Operation
- **Reset values:** every output is 0; state is `SYNC`; all counters are 0.
- **States:**
  - `SYNC` waits for `vsync` = 1, so a partial frame after reset is never captured.
  - `SYNC` → `ARM` when `vsync` = 1.
  - `ARM` exits when `vsync` = 0: to `ACTIVE` if `capture_en` = 1, else back to `SYNC` (the frame is skipped whole).
  - `ACTIVE` → `ARM` when `vsync` = 1, pulsing `frame_done`.
- **Byte index:** cleared whenever `href` = 0, so every line starts on byte 0. A partial pixel never carries across lines.
- **Pixel assembly:**
  - Each `href` = 1 cycle in `ACTIVE` stores `p_data` at byte slot `byte_idx`.
  - With `SWAP_BYTES` = 0, slot k occupies bits [8*(BPP−k)−1 : 8*(BPP−k−1)].
  - With `SWAP_BYTES` = 1, slot k occupies bits [8k+7 : 8k].
- **Pixel emit:** on the last byte (`byte_idx` = BPP−1), `byte_idx` wraps to 0 and `pixel_valid` is asserted next cycle with the coordinates of that pixel. `pixel_x` then increments.
- **Line end** (falling edge of `href` in `ACTIVE`):
  - `line_done` pulses.
  - The line is checked: if the pixel count ≠ `H_ACTIVE` or `byte_idx` ≠ 0, the error bit is set.
  - `pixel_x` clears and the line count increments.
- **Out-of-range pixels:** pixels with x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE` are suppressed (no `pixel_valid`) and set the error bit. Counters saturate; they never wrap.
- **Frame end:**
  - `frame_error` = error bit OR (line count ≠ `V_ACTIVE`).
  - `frame_count` increments.
  - The error bit and the X/Y counters clear.
- **`vsync` rising while `href` = 1:** `vsync` wins. `frame_done` pulses, no `line_done` is emitted, the truncated line counts as an error, and the partial pixel is discarded.
- **`capture_en` dropped mid-frame:** no effect; the current frame completes.
- **`reset` mid-frame:** abort immediately; no `frame_done`; return to `SYNC`.

## Timing
- All outputs are registered; latency is one `p_clock` from the sampled edge.
- `pixel_valid`: one cycle after the last byte is sampled. At most one per BPP cycles. With BPP = 1 it can be high every cycle.
- `line_done`: the cycle after the first `href` = 0 sample.
- `frame_done`: the cycle after the first `vsync` = 1 sample in `ACTIVE`. `frame_error` and the incremented `frame_count` are valid in that same cycle.
- Start of capture: the first byte is accepted on the first `href` = 1 sample after the `ARM` → `ACTIVE` transition. `ARM` is left on the first `vsync` = 0 sample.

## Structure
- Shared package `camera_pkg`:
  - state enum `SYNC`/`ARM`/`ACTIVE`;
  - default constants `CAM_H_ACTIVE` = 640, `CAM_V_ACTIVE` = 480, `CAM_BPP_RGB565` = 2;
  - a helper function for slot bit offsets.
- One sub-module, `camera_byte_packer`:
  - contents: byte index, slot steering, swap, pixel-complete flag;
  - parametrised by `BYTES_PER_PIXEL` and `SWAP_BYTES`;
  - the top level keeps the FSM, counters and checks.

## Test plan
All scenarios use H=4, V=2, BPP=2 unless stated.
- **Clean frame:** reset, vsync 1→0, `capture_en` = 1, two lines of 8 bytes (0x11,0x22,…) → 8 `pixel_valid`; first pixel `pixel_data` = 0x1122 at (0,0); last at (3,1); 2 `line_done`; `frame_done` with `frame_error` = 0; `frame_count` = 1.
- **Byte order:** `SWAP_BYTES` = 1, same stimulus → first pixel = 0x2211. BPP=3 → 0x112233. BPP=1 → valid every byte.
- **Geometry errors:**
  - 7-byte line → no pixel from the odd byte; `frame_error` = 1.
  - 3 lines → third line suppressed; `frame_error` = 1.
  - Next correct frame → `frame_error` = 0.
- **Arming:**
  - `capture_en` = 0 at frame start → no strobes for the whole frame.
  - `capture_en` raised mid-frame → capture begins only at the next frame.
  - Reset asserted while `vsync` = 0 → the first frame after reset is skipped.
- **Collisions:** `vsync` rises on the 5th byte of line 1 → `frame_done`, `frame_error` = 1, no `line_done` for that line. Reset mid-line → all outputs 0 next cycle, no `frame_done`.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and defaults for the DVP camera capture front end.
// No timing or flow control: types, constants and a slot-offset helper only.
package camera_pkg;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      ARM    = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam int CAM_H_ACTIVE   = 640;
   localparam int CAM_V_ACTIVE   = 480;
   localparam int CAM_BPP_RGB565 = 2;

   // LSB position of byte slot k within a bpp-byte pixel word.
   function automatic int slot_lsb(input int k, input int bpp, input logic swap);
      if (swap)
         return 8 * k;
      else
         return 8 * (bpp - 1 - k);
   endfunction

endpackage

// File: rtl/camera_byte_packer.sv
// Steers incoming sensor bytes into pixel slots; word/complete are combinational on the current byte.
// No backpressure: a byte is consumed every cycle en is high; index clears whenever en drops.
module camera_byte_packer
   import camera_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = CAM_BPP_RGB565,
   parameter int SWAP_BYTES      = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [7:0]                   data,
   output logic [1:0]                   byte_idx,
   output logic [8*BYTES_PER_PIXEL-1:0] word,
   output logic                         complete
);

   localparam int         W    = 8 * BYTES_PER_PIXEL;
   localparam logic [1:0] LAST = 2'(BYTES_PER_PIXEL - 1);

   logic [W-1:0] acc;
   int           off;

   assign complete = en && (byte_idx == LAST);

   always_comb begin
      off  = slot_lsb(int'(byte_idx), BYTES_PER_PIXEL, SWAP_BYTES != 0);
      word = acc;
      for (int p = 0; p < BYTES_PER_PIXEL; p++) begin
         if (off == 8 * p)
            word[8*p +: 8] = data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         byte_idx <= 2'd0;
      end else if (en) begin
         acc      <= word;
         byte_idx <= complete ? 2'd0 : byte_idx + 2'd1;
      end else begin
         byte_idx <= 2'd0;
      end
   end

endmodule

// File: rtl/camera_capture.sv
// DVP capture: frame arming FSM, X/Y counters, geometry checks; all outputs registered, 1 p_clock latency.
// No backpressure: the sensor cannot be stalled, so the frame-buffer side must accept every pixel_valid.
module camera_capture
   import camera_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = CAM_BPP_RGB565,
   parameter int H_ACTIVE        = CAM_H_ACTIVE,
   parameter int V_ACTIVE        = CAM_V_ACTIVE,
   parameter int SWAP_BYTES      = 0,
   parameter int X_W             = $clog2(H_ACTIVE),
   parameter int Y_W             = $clog2(V_ACTIVE)
) (
   input  logic                         p_clock,
   input  logic                         reset,
   input  logic                         vsync,
   input  logic                         href,
   input  logic [7:0]                   p_data,
   input  logic                         capture_en,
   output logic [8*BYTES_PER_PIXEL-1:0] pixel_data,
   output logic                         pixel_valid,
   output logic [X_W-1:0]               pixel_x,
   output logic [Y_W-1:0]               pixel_y,
   output logic                         line_done,
   output logic                         frame_done,
   output logic                         frame_error,
   output logic [15:0]                  frame_count
);

   // One extra bit so a full line/frame count (== H/V) is representable.
   localparam logic [X_W:0] H_CMP = (X_W + 1)'(H_ACTIVE);
   localparam logic [Y_W:0] V_CMP = (Y_W + 1)'(V_ACTIVE);

   state_t                       state;
   logic                         href_d;
   logic                         err;
   logic [X_W:0]                 x_cnt;
   logic [Y_W:0]                 y_cnt;
   logic                         byte_en;
   logic                         complete;
   logic [1:0]                   byte_idx;
   logic [8*BYTES_PER_PIXEL-1:0] word;
   logic                         in_range;

   assign byte_en  = (state == ACTIVE) && !vsync && href;
   assign in_range = (x_cnt < H_CMP) && (y_cnt < V_CMP);

   camera_byte_packer #(
      .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
      .SWAP_BYTES      (SWAP_BYTES)
   ) u_packer (
      .clk      (p_clock),
      .reset    (reset),
      .en       (byte_en),
      .data     (p_data),
      .byte_idx (byte_idx),
      .word     (word),
      .complete (complete)
   );

   always_ff @(posedge p_clock) begin
      if (reset) begin
         state       <= SYNC;
         href_d      <= 1'b0;
         err         <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         pixel_valid <= 1'b0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         // Only captured bytes count as "in a line", so arming never fakes a line end.
         href_d      <= byte_en;
         case (state)
            SYNC: begin
               if (vsync)
                  state <= ARM;
            end
            ARM: begin
               x_cnt <= '0;
               y_cnt <= '0;
               err   <= 1'b0;
               if (!vsync)
                  state <= capture_en ? ACTIVE : SYNC;
            end
            ACTIVE: begin
               if (vsync) begin
                  // vsync beats href: a line still in flight is truncated and flagged.
                  frame_done  <= 1'b1;
                  frame_error <= err || (y_cnt != V_CMP) || href || href_d;
                  frame_count <= frame_count + 16'd1;
                  x_cnt       <= '0;
                  y_cnt       <= '0;
                  err         <= 1'b0;
                  state       <= ARM;
               end else if (href) begin
                  if (complete) begin
                     if (in_range) begin
                        pixel_valid <= 1'b1;
                        pixel_data  <= word;
                        pixel_x     <= x_cnt[X_W-1:0];
                        pixel_y     <= y_cnt[Y_W-1:0];
                     end else begin
                        err <= 1'b1;
                     end
                     if (x_cnt != '1)
                        x_cnt <= x_cnt + 1'b1;
                  end
               end else if (href_d) begin
                  line_done <= 1'b1;
                  if ((x_cnt != H_CMP) || (byte_idx != 2'd0))
                     err <= 1'b1;
                  x_cnt <= '0;
                  if (y_cnt != '1)
                     y_cnt <= y_cnt + 1'b1;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench: four parameterisations share one DVP stimulus stream.
// u0 BPP2/H4/V2, u1 byte-swapped, u2 BPP3, u3 BPP1 with H8.
module tb_camera_capture;

   logic       p_clock = 1'b0;
   logic       reset = 1'b1;
   logic       vsync = 1'b0;
   logic       href = 1'b0;
   logic       capture_en = 1'b1;
   logic [7:0] p_data = 8'd0;

   always #5 p_clock = ~p_clock;

   logic [15:0] pd0, fc0;
   logic [1:0]  px0;
   logic        py0, pv0, ld0, fd0, fe0;
   logic [15:0] pd1, fc1;
   logic [1:0]  px1;
   logic        py1, pv1, ld1, fd1, fe1;
   logic [23:0] pd2;
   logic [15:0] fc2;
   logic [1:0]  px2;
   logic        py2, pv2, ld2, fd2, fe2;
   logic [7:0]  pd3;
   logic [15:0] fc3;
   logic [2:0]  px3;
   logic        py3, pv3, ld3, fd3, fe3;

   camera_capture #(.BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(2), .SWAP_BYTES(0)) u0 (
      .p_clock(p_clock), .reset(reset), .vsync(vsync), .href(href), .p_data(p_data),
      .capture_en(capture_en), .pixel_data(pd0), .pixel_valid(pv0), .pixel_x(px0),
      .pixel_y(py0), .line_done(ld0), .frame_done(fd0), .frame_error(fe0), .frame_count(fc0));
   camera_capture #(.BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(2), .SWAP_BYTES(1)) u1 (
      .p_clock(p_clock), .reset(reset), .vsync(vsync), .href(href), .p_data(p_data),
      .capture_en(capture_en), .pixel_data(pd1), .pixel_valid(pv1), .pixel_x(px1),
      .pixel_y(py1), .line_done(ld1), .frame_done(fd1), .frame_error(fe1), .frame_count(fc1));
   camera_capture #(.BYTES_PER_PIXEL(3), .H_ACTIVE(4), .V_ACTIVE(2), .SWAP_BYTES(0)) u2 (
      .p_clock(p_clock), .reset(reset), .vsync(vsync), .href(href), .p_data(p_data),
      .capture_en(capture_en), .pixel_data(pd2), .pixel_valid(pv2), .pixel_x(px2),
      .pixel_y(py2), .line_done(ld2), .frame_done(fd2), .frame_error(fe2), .frame_count(fc2));
   camera_capture #(.BYTES_PER_PIXEL(1), .H_ACTIVE(8), .V_ACTIVE(2), .SWAP_BYTES(0)) u3 (
      .p_clock(p_clock), .reset(reset), .vsync(vsync), .href(href), .p_data(p_data),
      .capture_en(capture_en), .pixel_data(pd3), .pixel_valid(pv3), .pixel_x(px3),
      .pixel_y(py3), .line_done(ld3), .frame_done(fd3), .frame_error(fe3), .frame_count(fc3));

   int n_cmp = 0;
   int n_err = 0;

   int          pix0 = 0, lines0 = 0, frames0 = 0;
   logic [15:0] first_d0 = '0, last_d0 = '0;
   logic [1:0]  first_x0 = '0, last_x0 = '0;
   logic        first_y0 = 1'b0, last_y0 = 1'b0, err0 = 1'b0;
   int          pix1 = 0, pix2 = 0, pix3 = 0, run3 = 0, maxrun3 = 0;
   logic [15:0] first_d1 = '0;
   logic [23:0] first_d2 = '0;
   logic        err3 = 1'b0;

   always @(negedge p_clock) begin
      if (pv0) begin
         if (pix0 == 0) begin
            first_d0 <= pd0;
            first_x0 <= px0;
            first_y0 <= py0;
         end
         last_d0 <= pd0;
         last_x0 <= px0;
         last_y0 <= py0;
         pix0    <= pix0 + 1;
      end
      if (ld0)
         lines0 <= lines0 + 1;
      if (fd0) begin
         frames0 <= frames0 + 1;
         err0    <= fe0;
      end
      if (pv1) begin
         if (pix1 == 0)
            first_d1 <= pd1;
         pix1 <= pix1 + 1;
      end
      if (pv2) begin
         if (pix2 == 0)
            first_d2 <= pd2;
         pix2 <= pix2 + 1;
      end
      if (pv3) begin
         pix3 <= pix3 + 1;
         run3 <= run3 + 1;
         if (run3 + 1 > maxrun3)
            maxrun3 <= run3 + 1;
      end else begin
         run3 <= 0;
      end
      if (fd3)
         err3 <= fe3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge p_clock);
      pix0 = 0; lines0 = 0; frames0 = 0; err0 = 1'b0;
      pix1 = 0; pix2 = 0; pix3 = 0; run3 = 0; maxrun3 = 0; err3 = 1'b0;
   endtask

   task automatic step(input logic v, input logic h, input logic [7:0] d);
      @(negedge p_clock);
      vsync  = v;
      href   = h;
      p_data = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
   endtask

   task automatic line(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 8'(i * 17));
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      idle(3);
      chk("rst_pixel_valid", 32'(pv0), 0);
      chk("rst_pixel_data", 32'(pd0), 0);
      chk("rst_pixel_x", 32'(px0), 0);
      chk("rst_pixel_y", 32'(py0), 0);
      chk("rst_line_done", 32'(ld0), 0);
      chk("rst_frame_done", 32'(fd0), 0);
      chk("rst_frame_error", 32'(fe0), 0);
      chk("rst_frame_count", 32'(fc0), 0);
      reset = 1'b0;

      // Reset released mid-frame (vsync low): that partial frame is ignored
      line(8, 8'h11);
      chk("skip_after_reset_pix", 32'(pix0), 0);
      chk("skip_after_reset_line", 32'(lines0), 0);

      // Clean frame
      vblank(3);
      clear_mon();
      idle(2);
      line(8, 8'h11);
      line(8, 8'h99);
      vblank(3);
      chk("clean_pix_count", 32'(pix0), 8);
      chk("clean_first_data", 32'(first_d0), 32'h1122);
      chk("clean_first_x", 32'(first_x0), 0);
      chk("clean_first_y", 32'(first_y0), 0);
      chk("clean_last_data", 32'(last_d0), 32'hFF10);
      chk("clean_last_x", 32'(last_x0), 3);
      chk("clean_last_y", 32'(last_y0), 1);
      chk("clean_lines", 32'(lines0), 2);
      chk("clean_frames", 32'(frames0), 1);
      chk("clean_error", 32'(err0), 0);
      chk("clean_frame_count", 32'(fc0), 1);
      chk("swap_first_data", 32'(first_d1), 32'h2211);
      chk("bpp3_first_data", 32'(first_d2), 32'h112233);
      chk("bpp1_pix_count", 32'(pix3), 16);
      chk("bpp1_back_to_back", 32'(maxrun3), 8);
      chk("bpp1_error", 32'(err3), 0);

      // 7-byte line: odd byte yields no pixel, frame flagged
      clear_mon();
      idle(2);
      line(7, 8'h11);
      line(8, 8'h99);
      vblank(3);
      chk("short_pix_count", 32'(pix0), 7);
      chk("short_error", 32'(err0), 1);
      chk("short_frame_count", 32'(fc0), 2);

      // Three lines: third line suppressed, frame flagged
      clear_mon();
      idle(2);
      line(8, 8'h11);
      line(8, 8'h99);
      line(8, 8'h31);
      vblank(3);
      chk("tall_pix_count", 32'(pix0), 8);
      chk("tall_lines", 32'(lines0), 3);
      chk("tall_error", 32'(err0), 1);

      // Following correct frame is clean again
      clear_mon();
      idle(2);
      line(8, 8'h11);
      line(8, 8'h99);
      vblank(3);
      chk("recover_pix_count", 32'(pix0), 8);
      chk("recover_error", 32'(err0), 0);
      chk("recover_frame_count", 32'(fc0), 4);

      // Disarmed at frame start, raised mid-frame: whole frame skipped
      clear_mon();
      capture_en = 1'b0;
      idle(2);
      line(8, 8'h11);
      capture_en = 1'b1;
      line(8, 8'h99);
      vblank(3);
      chk("disarm_pix_count", 32'(pix0), 0);
      chk("disarm_lines", 32'(lines0), 0);
      chk("disarm_frames", 32'(frames0), 0);
      chk("disarm_frame_count", 32'(fc0), 4);

      // Armed frame, capture_en dropped mid-frame: frame still completes
      clear_mon();
      idle(2);
      line(8, 8'h11);
      capture_en = 1'b0;
      line(8, 8'h99);
      capture_en = 1'b1;
      vblank(3);
      chk("drop_pix_count", 32'(pix0), 8);
      chk("drop_frames", 32'(frames0), 1);
      chk("drop_error", 32'(err0), 0);
      chk("drop_frame_count", 32'(fc0), 5);

      // vsync rises on the 5th byte of line 1
      clear_mon();
      idle(2);
      line(8, 8'h11);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h40 + 8'(i));
      step(1'b1, 1'b1, 8'h44);
      vblank(3);
      chk("collide_pix_count", 32'(pix0), 6);
      chk("collide_lines", 32'(lines0), 1);
      chk("collide_frames", 32'(frames0), 1);
      chk("collide_error", 32'(err0), 1);
      chk("collide_frame_count", 32'(fc0), 6);

      // Reset mid-line: outputs clear next cycle, no frame_done afterwards
      clear_mon();
      idle(2);
      line(8, 8'h11);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h50 + 8'(i));
      reset = 1'b1;
      step(1'b0, 1'b1, 8'h53);
      chk("midrst_pixel_valid", 32'(pv0), 0);
      chk("midrst_pixel_data", 32'(pd0), 0);
      chk("midrst_pixel_x", 32'(px0), 0);
      chk("midrst_frame_count", 32'(fc0), 0);
      reset = 1'b0;
      vblank(3);
      chk("midrst_frames", 32'(frames0), 0);
      chk("midrst_frame_done", 32'(fd0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
